spi_rx_slave: RTL

//   SPI mode-0 receive-only responder: the peripheral end of our write-only SPI

---
 rtl/spi_rx_if.sv | 17 +
 rtl/spi_rx_slave.sv | 92 +++++++++
 2 files changed

// File: rtl/spi_rx_if.sv
// spi_rx_if: SPI pins plus received-word valid/ready and status for spi_rx_slave
interface spi_rx_if #(parameter int WORD_BITS = 8);
  logic                 sck_i;
  logic                 sdi_i;
  logic                 cs_i;
  logic                 ready_i;
  logic                 clr_i;
  logic [WORD_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 busy_o;
  logic                 frame_err_o;
  logic                 overrun_o;
  modport slave (input sck_i, sdi_i, cs_i, ready_i, clr_i,
                 output data_o, valid_o, busy_o, frame_err_o, overrun_o);
  modport master (output sck_i, sdi_i, cs_i, ready_i, clr_i,
                  input data_o, valid_o, busy_o, frame_err_o, overrun_o);
endinterface

// File: rtl/spi_rx_slave.sv
// spi_rx_slave: oversampled SPI mode-0 receiver with a 1-entry valid/ready holding register
module spi_rx_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = 8
) (
  input logic     clk_i,
  input logic     rst_i,
  spi_rx_if.slave bus
);
  localparam int CW = $clog2(WORD_BITS + 1);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;
  state_t               state, state_n;
  logic [SYNC_STAGES:0] sck_s, sdi_s, cs_s;
  logic [SYNC_STAGES-1:0] primed;
  logic [CW-1:0]        cnt, cnt_n;
  logic [WORD_BITS-1:0] shift, shift_n, data, data_n;
  logic                 valid, valid_n, ferr, ferr_n, ovr, ovr_n, done;
  logic                 sck_rise, cs_rise, cs_fall, cs_cur, sdi_bit;
  assign cs_cur   = cs_s[SYNC_STAGES-1];
  assign sdi_bit  = sdi_s[SYNC_STAGES-1];
  assign sck_rise = ~sck_s[SYNC_STAGES] & sck_s[SYNC_STAGES-1];
  assign cs_rise  = ~cs_s[SYNC_STAGES] & cs_cur;
  assign cs_fall  = cs_s[SYNC_STAGES] & ~cs_cur;
  assign bus.data_o      = data;
  assign bus.valid_o     = valid;
  assign bus.busy_o      = (state == ACTIVE);
  assign bus.frame_err_o = ferr;
  assign bus.overrun_o   = ovr;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_s  <= '0;
      sdi_s  <= '0;
      cs_s   <= '1;
      primed <= '0;
      state  <= WAIT_IDLE;
      cnt    <= '0;
      shift  <= '0;
      data   <= '0;
      valid  <= 1'b0;
      ferr   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      sck_s  <= {sck_s[SYNC_STAGES-1:0], bus.sck_i};
      sdi_s  <= {sdi_s[SYNC_STAGES-1:0], bus.sdi_i};
      cs_s   <= {cs_s[SYNC_STAGES-1:0], bus.cs_i};
      primed <= {primed[SYNC_STAGES-2:0], 1'b1};
      state  <= state_n;
      cnt    <= cnt_n;
      shift  <= shift_n;
      data   <= data_n;
      valid  <= valid_n;
      ferr   <= ferr_n;
      ovr    <= ovr_n;
    end
  end
  // The cs preset after reset is not a real pin sample, so idle is only trusted once the chain has refilled.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    data_n  = data;
    valid_n = valid & ~bus.ready_i;
    ferr_n  = 1'b0;
    ovr_n   = ovr & ~bus.clr_i;
    done    = 1'b0;
    case (state)
      WAIT_IDLE: state_n = (primed[SYNC_STAGES-1] & cs_cur) ? IDLE : WAIT_IDLE;
      IDLE: begin
        state_n = cs_fall ? ACTIVE : IDLE;
        cnt_n   = cs_fall ? '0 : cnt;
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_n = IDLE;
          cnt_n   = '0;
          ferr_n  = (cnt != '0);
        end else if (sck_rise) begin
          shift_n = {shift[WORD_BITS-2:0], sdi_bit};
          done    = (cnt == CW'(WORD_BITS - 1));
          cnt_n   = done ? '0 : cnt + 1'b1;
        end
      end
      default: state_n = WAIT_IDLE;
    endcase
    if (done && (!valid || bus.ready_i)) begin
      data_n  = shift_n;
      valid_n = 1'b1;
    end else if (done) begin
      ovr_n = 1'b1;
    end
  end
endmodule
